// File: rtl/dbus_sram_responder.sv
// Data-bus slave responder: one outstanding request, fixed accept-to-data_ok latency,
// backed by a word-addressed SRAM with per-byte write strobes.
module dbus_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [31:0] resp_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WORDS = 2 ** DEPTH_LOG2;

    state_t                  state;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   holdIdx;
    logic [3:0]              holdStrobe;
    logic [31:0]             holdData;
    logic [31:0]             mem [0:WORDS-1];
    logic [DEPTH_LOG2-1:0]   reqIdx;

    // Size and the non-index address bits carry no meaning for this model.
    logic unusedBits;
    assign unusedBits = ^{req_size, req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

    assign reqIdx       = req_addr[DEPTH_LOG2+1:2];
    assign resp_addr_ok = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            holdIdx      <= '0;
            holdStrobe   <= '0;
            holdData     <= '0;
            resp_data_ok <= 1'b0;
            resp_data    <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        holdIdx    <= reqIdx;
                        holdStrobe <= req_strobe;
                        holdData   <= req_data;
                        busy       <= 1'b1;
                        cnt        <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            // Straight to RESP: read from the incoming request, not the hold regs.
                            state        <= RESP;
                            resp_data_ok <= 1'b1;
                            resp_data    <= (req_strobe == 4'h0) ? mem[reqIdx] : 32'h0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state        <= RESP;
                        resp_data_ok <= 1'b1;
                        resp_data    <= (holdStrobe == 4'h0) ? mem[holdIdx] : 32'h0;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_data_ok <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    resp_data_ok <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Commit on the edge that ends RESP; an async reset before then drops the write.
    always_ff @(posedge clk) begin
        if (state == RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (holdStrobe[i]) mem[holdIdx][8*i +: 8] <= holdData[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomized bench for dbus_sram_responder against a word-array memory model.
module tb_dbus_sram_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        reqValid = 1'b0, v1 = 1'b0, v15 = 1'b0;
    logic [31:0] reqAddr = '0, reqData = '0;
    logic [2:0]  reqSize = 3'd2;
    logic [3:0]  reqStrobe = '0;
    logic        ao2, do2, bz2, ao1, do1, bz1, ao15, do15, bz15;
    logic [31:0] rd2, rd1, rd15;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [0:1023];
    bit          known [0:1023];

    always #5 clk = ~clk;

    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(reqValid), .req_addr(reqAddr),
        .req_size(reqSize), .req_strobe(reqStrobe), .req_data(reqData),
        .resp_addr_ok(ao2), .resp_data_ok(do2), .resp_data(rd2), .busy(bz2));
    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .req_valid(v1), .req_addr(reqAddr),
        .req_size(reqSize), .req_strobe(reqStrobe), .req_data(reqData),
        .resp_addr_ok(ao1), .resp_data_ok(do1), .resp_data(rd1), .busy(bz1));
    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(15)) dut15 (
        .clk(clk), .resetn(resetn), .req_valid(v15), .req_addr(reqAddr),
        .req_size(reqSize), .req_strobe(reqStrobe), .req_data(reqData),
        .resp_addr_ok(ao15), .resp_data_ok(do15), .resp_data(rd15), .busy(bz15));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                          input logic [31:0] d);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Drives one request into dut2 and reports accept, latency (-1 on timeout) and data.
    task automatic drive2(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output bit acc, output int lat, output logic [31:0] rdata);
        @(negedge clk);
        reqValid = 1'b1; reqAddr = a; reqStrobe = s; reqData = d;
        #1 acc = ao2;
        @(negedge clk);
        reqValid = 1'b0;
        lat = -1; rdata = 'x;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (do2) begin lat = k; rdata = rd2; break; end
            @(negedge clk);
        end
        if (lat > 0 && s == 4'h0) begin
            if (!known[a[11:2]]) begin known[a[11:2]] = 1'b1; model[a[11:2]] = rdata; end
        end else if (lat > 0) begin
            model[a[11:2]] = merge(known[a[11:2]] ? model[a[11:2]] : 32'h0, s, d);
            if (s != 4'hF && !known[a[11:2]]) known[a[11:2]] = 1'b0;
            else known[a[11:2]] = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0; reqValid = 1'b0; v1 = 1'b0; v15 = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({ao2, do2, bz2, rd2, ao1, do1, bz1, rd1, ao15, do15, bz15, rd15} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%h/%h required all zero", rd2, rd1, rd15);
        end
        doReset();
    endtask

    task automatic checkTxn(input string nm, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic [31:0] exp);
        bit acc; int lat; logic [31:0] r;
        drive2(a, s, d, acc, lat, r);
        vectors++;
        if (acc !== 1'b1 || lat != 2 || r !== exp) begin
            miscompares++;
            $display("FAIL %s: acc=%0b lat=%0d data=%h required acc=1 lat=2 data=%h",
                     nm, acc, lat, r, exp);
        end
    endtask

    task automatic test_write_read();
        checkTxn("write_full", 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        checkTxn("read_full", 32'h10, 4'h0, 32'h0, 32'hDEADBEEF);
    endtask

    task automatic test_partial();
        checkTxn("partial_init", 32'h20, 4'hF, 32'h11223344, 32'h0);
        checkTxn("partial_wr", 32'h20, 4'b0010, 32'h0000AA00, 32'h0);
        checkTxn("partial_rd", 32'h20, 4'h0, 32'h0, 32'h1122AA44);
    endtask

    task automatic test_alias();
        checkTxn("alias_wr", 32'h00001004, 4'hF, 32'hCAFEF00D, 32'h0);
        checkTxn("alias_rd", 32'h00000004, 4'h0, 32'h0, 32'hCAFEF00D);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d, exp; logic [3:0] s; int idx;
            bit acc; int lat; logic [31:0] r; bit chk;
            idx = 64 + $urandom_range(0, 7);
            a = {$urandom_range(0, 1048575), 10'(idx), 2'($urandom_range(0, 3))};
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            if (!known[idx] && s != 4'h0) s = 4'hF;
            d = $urandom;
            chk = (s != 4'h0) || known[idx];
            exp = (s != 4'h0) ? 32'h0 : model[idx];
            drive2(a, s, d, acc, lat, r);
            vectors++;
            if (acc !== 1'b1 || lat != 2 || (chk && r !== exp)) begin
                miscompares++;
                $display("FAIL random_%0d: addr=%h strb=%h acc=%0b lat=%0d data=%h required lat=2 data=%h",
                         n, a, s, acc, lat, r, exp);
            end
        end
    endtask

    task automatic test_held();
        int accs[$]; int doks[$]; bit prevDo = 0; int bad = 0;
        @(negedge clk);
        reqValid = 1'b1; reqAddr = 32'h10; reqStrobe = 4'h0; reqData = '0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (ao2) accs.push_back(c);
            if (do2) begin
                doks.push_back(c);
                if (rd2 !== model[4]) bad++;
            end
            if (ao2 && bz2) bad++;
            if (do2 && prevDo) bad++;
            prevDo = do2;
            @(negedge clk);
        end
        reqValid = 1'b0;
        vectors++;
        if (accs.size() != 3 || accs[0] != 0 || accs[1] != 3 || accs[2] != 6 ||
            doks.size() != 3 || doks[0] != 2 || doks[1] != 5 || doks[2] != 8 || bad != 0) begin
            miscompares++;
            $display("FAIL held_request: accepts=%p data_oks=%p violations=%0d required accepts 0,3,6 data_oks 2,5,8",
                     accs, doks, bad);
        end
    endtask

    task automatic test_latency_corners();
        bit a1, d1, a15; int busyCnt = 0; int dokAt = -1;
        @(negedge clk);
        v1 = 1'b1; reqAddr = 32'h0; reqStrobe = 4'h0;
        #1 a1 = ao1;
        @(negedge clk);
        v1 = 1'b0;
        #1 d1 = do1;
        vectors++;
        if (a1 !== 1'b1 || d1 !== 1'b1) begin
            miscompares++;
            $display("FAIL latency1: acc=%0b data_ok_at_T+1=%0b required 1/1", a1, d1);
        end
        @(negedge clk);
        v15 = 1'b1;
        #1 a15 = ao15;
        @(negedge clk);
        v15 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            #1;
            if (bz15) busyCnt++;
            if (do15 && dokAt < 0) dokAt = k;
            @(negedge clk);
        end
        vectors++;
        if (a15 !== 1'b1 || dokAt != 15 || busyCnt != 15) begin
            miscompares++;
            $display("FAIL latency15: acc=%0b data_ok_at=%0d busy_cycles=%0d required 1/15/15",
                     a15, dokAt, busyCnt);
        end
    endtask

    task automatic test_reset_midop();
        int sawDo = 0;
        checkTxn("midop_prior", 32'h40, 4'hF, 32'h12345678, 32'h0);
        @(negedge clk);
        reqValid = 1'b1; reqAddr = 32'h40; reqStrobe = 4'hF; reqData = 32'h55;
        @(negedge clk);
        reqValid = 1'b0;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({ao2, do2, bz2, rd2} !== '0) begin
            miscompares++;
            $display("FAIL midop_outputs: ao=%0b do=%0b busy=%0b data=%h required all zero",
                     ao2, do2, bz2, rd2);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 if (do2) sawDo++;
            @(negedge clk);
        end
        vectors++;
        if (sawDo != 0) begin
            miscompares++;
            $display("FAIL midop_no_data_ok: data_ok cycles=%0d required 0", sawDo);
        end
        checkTxn("midop_read", 32'h40, 4'h0, 32'h0, 32'h12345678);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin known[i] = 1'b0; model[i] = '0; end
        test_reset();
        test_write_read();
        test_partial();
        test_alias();
        test_random();
        test_held();
        test_latency_corners();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
